// File: rtl/mul_mac_pipe.sv
// Two-stage pipelined multiply-accumulate unit with NUM_MR guarded accumulators,
// saturation, MR clear and a sticky overflow flag.
module mul_mac_pipe #(
  parameter int unsigned RF_DATASIZE = 16,
  parameter int unsigned NUM_MR      = 2,
  parameter int unsigned MR_GUARD    = 8,
  parameter int unsigned MRSEL_W     = (NUM_MR > 1) ? $clog2(NUM_MR) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RF_DATASIZE-1:0] xb_cu_rx,
  input  logic [RF_DATASIZE-1:0] xb_cu_ry,
  input  logic                   ps_mul_en,
  input  logic                   ps_mul_otreg,
  input  logic [3:0]             ps_mul_dtsts,
  input  logic [1:0]             ps_mul_cls,
  input  logic [MRSEL_W-1:0]     ps_mul_mrsel,
  input  logic                   ps_mul_clr,
  input  logic                   ps_mul_mos_clr,
  output logic [RF_DATASIZE-1:0] mul_xb_rn,
  output logic                   mul_xb_valid,
  output logic                   mul_ps_ov,
  output logic                   mul_ps_mn,
  output logic                   mul_ps_mos
);

  localparam int unsigned N = RF_DATASIZE;
  localparam int unsigned W = 2 * N + MR_GUARD;

  localparam logic [W-1:0] RoundBit = W'(1) << (N - 1);
  localparam logic [W-1:0] IntMask  = {{(W - N){1'b0}}, {N{1'b1}}};
  localparam logic [W-1:0] FracMask = {{(W - 2 * N){1'b0}}, {(2 * N){1'b1}}};

  // Stage 1 registers
  logic [N-1:0]       rx_q, ry_q;
  logic [3:0]         dtsts_q;
  logic [1:0]         cls_q;
  logic               otreg_q, clr_q, v1_q;
  logic [MRSEL_W-1:0] mrsel_q;

  // Stage 2 registers; sts2_q = {ry signed, rx signed, fractional}
  logic [W-1:0]       prod_d, prod_q;
  logic [2:0]         sts2_q;
  logic [1:0]         cls2_q;
  logic               otreg2_q, clr2_q, v2_q;
  logic [MRSEL_W-1:0] mrsel2_q;

  // Stage 3 state
  logic [W-1:0] mr_q [NUM_MR];
  logic [N-1:0] rn_q;
  logic         valid_q, ov_q, mn_q, mos_q;

  logic [W-1:0] opx, opy;
  logic [W-1:0] mr_cur, lim_mask, sat_d, result_d;
  logic         frac, mr_sgn, any_sgn, ov_d, mn_d;

  // True when v lies outside the representable range for the given mode.
  function automatic logic range_ov(logic [W-1:0] v, logic sgn, logic frc);
    if (sgn && frc)  return !((&v[W-1:2*N-1]) || !(|v[W-1:2*N-1]));
    else if (sgn)    return !((&v[W-1:N-1]) || !(|v[W-1:N-1]));
    else if (frc)    return |v[W-1:2*N];
    else             return |v[W-1:N];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      rx_q    <= '0;
      ry_q    <= '0;
      dtsts_q <= '0;
      cls_q   <= '0;
      otreg_q <= 1'b0;
      clr_q   <= 1'b0;
      mrsel_q <= '0;
    end else begin
      v1_q <= ps_mul_en;
      if (ps_mul_en) begin
        rx_q    <= xb_cu_rx;
        ry_q    <= xb_cu_ry;
        dtsts_q <= ps_mul_dtsts;
        cls_q   <= ps_mul_cls;
        otreg_q <= ps_mul_otreg;
        clr_q   <= ps_mul_clr;
        mrsel_q <= ps_mul_mrsel;
      end
    end
  end

  // Operands extended straight to W bits so mixed-sign products keep their sign.
  always_comb begin
    opx    = {{(W - N){dtsts_q[2] & rx_q[N-1]}}, rx_q};
    opy    = {{(W - N){dtsts_q[3] & ry_q[N-1]}}, ry_q};
    prod_d = opx * opy;
    if (dtsts_q[1] && dtsts_q[2] && dtsts_q[3]) prod_d = prod_d << 1;
    if (dtsts_q[1] && dtsts_q[0])               prod_d = prod_d + RoundBit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q     <= 1'b0;
      prod_q   <= '0;
      sts2_q   <= '0;
      cls2_q   <= '0;
      otreg2_q <= 1'b0;
      clr2_q   <= 1'b0;
      mrsel2_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        prod_q   <= prod_d;
        sts2_q   <= dtsts_q[3:1];
        cls2_q   <= cls_q;
        otreg2_q <= otreg_q;
        clr2_q   <= clr_q;
        mrsel2_q <= mrsel_q;
      end
    end
  end

  always_comb begin
    mr_cur   = mr_q[mrsel2_q];
    frac     = sts2_q[0];
    mr_sgn   = sts2_q[1];
    any_sgn  = sts2_q[2] | sts2_q[1];
    lim_mask = frac ? FracMask : IntMask;
    if (!range_ov(mr_cur, mr_sgn, frac)) sat_d = mr_cur;
    else if (mr_sgn)                     sat_d = mr_cur[W-1] ? ~(lim_mask >> 1) : (lim_mask >> 1);
    else                                 sat_d = lim_mask;
    result_d = '0;
    if (!clr2_q) begin
      unique case (cls2_q)
        2'b00:   result_d = sat_d;
        2'b01:   result_d = prod_q;
        2'b10:   result_d = mr_cur + prod_q;
        default: result_d = mr_cur - prod_q;
      endcase
    end
    ov_d = !clr2_q && (cls2_q != 2'b00) && range_ov(result_d, any_sgn, frac);
    mn_d = !clr2_q && any_sgn && result_d[W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_MR; i++) mr_q[i] <= '0;
      rn_q    <= '0;
      valid_q <= 1'b0;
      ov_q    <= 1'b0;
      mn_q    <= 1'b0;
      mos_q   <= 1'b0;
    end else begin
      valid_q <= v2_q;
      if (v2_q) begin
        rn_q <= frac ? result_d[2*N-1:N] : result_d[N-1:0];
        ov_q <= ov_d;
        mn_q <= mn_d;
        if (otreg2_q || clr2_q) mr_q[mrsel2_q] <= result_d;
      end
      // A new overflow beats a simultaneous clear.
      if (v2_q && ov_d)        mos_q <= 1'b1;
      else if (ps_mul_mos_clr) mos_q <= 1'b0;
    end
  end

  assign mul_xb_rn    = rn_q;
  assign mul_xb_valid = valid_q;
  assign mul_ps_ov    = ov_q;
  assign mul_ps_mn    = mn_q;
  assign mul_ps_mos   = mos_q;

endmodule

// File: tb/tb_mul_mac_pipe.sv
// Scoreboard bench for mul_mac_pipe: an arithmetic model predicts each result at
// issue time; a negedge monitor pops and compares when the DUT strobes valid.
module tb_mul_mac_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] rx = '0, ry = '0;
  logic        en = 1'b0, otreg = 1'b0, clr = 1'b0, mos_clr = 1'b0;
  logic [3:0]  dtsts = '0;
  logic [1:0]  cls = '0;
  logic [0:0]  mrsel = '0;
  logic [15:0] rn;
  logic        valid, ov, mn, mos;

  mul_mac_pipe dut (
    .clk            (clk),
    .rst            (rst),
    .xb_cu_rx       (rx),
    .xb_cu_ry       (ry),
    .ps_mul_en      (en),
    .ps_mul_otreg   (otreg),
    .ps_mul_dtsts   (dtsts),
    .ps_mul_cls     (cls),
    .ps_mul_mrsel   (mrsel),
    .ps_mul_clr     (clr),
    .ps_mul_mos_clr (mos_clr),
    .mul_xb_rn      (rn),
    .mul_xb_valid   (valid),
    .mul_ps_ov      (ov),
    .mul_ps_mn      (mn),
    .mul_ps_mos     (mos)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rn;
    logic        ov;
    logic        mn;
    logic [39:0] mr;
    int          sel;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [39:0] mdl_mr [2];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint sx40(input logic [39:0] v);
    return longint'($signed(v));
  endfunction

  function automatic void bounds(input bit sgn, input bit frc, output longint lo, output longint hi);
    if (sgn && frc)  begin lo = -(64'sd1 <<< 31); hi = (64'sd1 <<< 31) - 1; end
    else if (sgn)    begin lo = -64'sd32768;      hi = 64'sd32767; end
    else if (frc)    begin lo = 0;                hi = (64'sd1 <<< 32) - 1; end
    else             begin lo = 0;                hi = 64'sd65535; end
  endfunction

  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] dt, input logic [1:0] c, input logic cl,
                                input logic [39:0] mr, output logic [39:0] r,
                                output logic o, output logic m);
    longint x, y, p, v, lo, hi;
    logic [63:0] pv;
    bit any_s, frc;
    any_s = dt[3] | dt[2];
    frc   = dt[1];
    x = dt[2] ? longint'($signed(a)) : longint'({48'b0, a});
    y = dt[3] ? longint'($signed(b)) : longint'({48'b0, b});
    p = x * y;
    if (frc && dt[2] && dt[3]) p = p * 2;
    if (frc && dt[0])          p = p + 64'sd32768;
    pv = p;
    o = 1'b0;
    if (cl) begin
      r = '0;
      m = 1'b0;
      return;
    end
    if (c == 2'b00) begin
      v = dt[2] ? sx40(mr) : longint'({24'b0, mr});
      bounds(dt[2], frc, lo, hi);
      if (v > hi) v = hi;
      if (v < lo) v = lo;
      pv = v;
      r  = pv[39:0];
    end else begin
      if (c == 2'b01)      r = pv[39:0];
      else if (c == 2'b10) r = mr + pv[39:0];
      else                 r = mr - pv[39:0];
      v = any_s ? sx40(r) : longint'({24'b0, r});
      bounds(any_s, frc, lo, hi);
      o = (v < lo) || (v > hi);
    end
    m = any_s & r[39];
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] dt,
                       input logic [1:0] c, input logic ot, input int sel, input logic cl);
    exp_t e;
    logic [39:0] r;
    logic o, m;
    model(a, b, dt, c, cl, mdl_mr[sel], r, o, m);
    if (ot || cl) mdl_mr[sel] = r;
    e.rn  = dt[1] ? r[31:16] : r[15:0];
    e.ov  = o;
    e.mn  = m;
    e.mr  = mdl_mr[sel];
    e.sel = sel;
    e.cyc = cyc + 1;
    sb.push_back(e);
    rx = a; ry = b; dtsts = dt; cls = c; otreg = ot; mrsel = 1'(sel); clr = cl; en = 1'b1;
    @(posedge clk);
    #1;
    en  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    check("drain_pending", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", valid, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rn", rn, e.rn);
        check("ov", ov, e.ov);
        check("mn", mn, e.mn);
        check("mr", dut.mr_q[e.sel], e.mr);
        check("latency", cyc - e.cyc, 2);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mdl_mr[0] = '0;
    mdl_mr[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_rn", rn, 16'h0);
    check("rst_valid", valid, 1'b0);
    check("rst_ov", ov, 1'b0);
    check("rst_mn", mn, 1'b0);
    check("rst_mos", mos, 1'b0);
    check("rst_mr0", dut.mr_q[0], 40'h0);

    // Unsigned integer 3x5 to Rn
    issue(16'd3, 16'd5, 4'b0000, 2'b01, 1'b0, 0, 1'b0);
    drain();
    check("u3x5_rn", rn, 16'h000F);

    // Signed fractional products with rounding; the second overflows
    issue(16'h4000, 16'h4000, 4'b1111, 2'b01, 1'b0, 0, 1'b0);
    issue(16'h8000, 16'h8000, 4'b1111, 2'b01, 1'b0, 0, 1'b0);
    drain();
    check("frac_ov_mos", mos, 1'b1);

    // Back-to-back signed accumulate into MR0
    issue(16'd2, 16'd3, 4'b1100, 2'b10, 1'b1, 0, 1'b0);
    issue(16'd4, 16'd5, 4'b1100, 2'b10, 1'b1, 0, 1'b0);
    issue(16'hFFFF, 16'd7, 4'b1100, 2'b10, 1'b1, 0, 1'b0);
    drain();
    check("b2b_mr0", dut.mr_q[0], 40'd19);

    // Interleaved MR0 / MR1, then subtract from a cleared MR1
    issue(16'd3, 16'd3, 4'b1100, 2'b10, 1'b1, 1, 1'b0);
    issue(16'd1, 16'd1, 4'b1100, 2'b10, 1'b1, 0, 1'b0);
    issue(16'd2, 16'd2, 4'b1100, 2'b10, 1'b1, 1, 1'b0);
    issue(16'd0, 16'd0, 4'b1100, 2'b10, 1'b1, 1, 1'b1);
    issue(16'd10, 16'd10, 4'b1100, 2'b11, 1'b1, 1, 1'b0);
    drain();
    check("sub_mr1", dut.mr_q[1], 40'hFFFFFFFF9C);
    check("sub_mn", mn, 1'b1);
    check("mr0_untouched", dut.mr_q[0], 40'd20);

    // Saturation cases
    issue(16'd0, 16'd0, 4'b0000, 2'b00, 1'b0, 0, 1'b1);
    issue(16'h1234, 16'h0010, 4'b0000, 2'b10, 1'b1, 0, 1'b0);
    issue(16'd1, 16'd5, 4'b0000, 2'b10, 1'b1, 0, 1'b0);
    issue(16'd0, 16'd0, 4'b0100, 2'b00, 1'b0, 0, 1'b0);
    drain();
    check("sat_rn", rn, 16'h7FFF);
    check("sat_mr0_kept", dut.mr_q[0], 40'h0000012345);
    issue(16'd0, 16'd0, 4'b0100, 2'b00, 1'b1, 0, 1'b0);
    drain();
    check("sat_mr0_wr", dut.mr_q[0], 40'h0000007FFF);
    issue(16'd0, 16'd0, 4'b0100, 2'b00, 1'b0, 1, 1'b0);
    issue(16'd0, 16'd0, 4'b0000, 2'b00, 1'b0, 1, 1'b0);
    issue(16'd0, 16'd0, 4'b0110, 2'b00, 1'b0, 1, 1'b0);
    issue(16'd0, 16'd0, 4'b0000, 2'b00, 1'b0, 0, 1'b1);
    drain();
    check("clr_mr0", dut.mr_q[0], 40'h0);

    // Random mix through the scoreboard
    for (int i = 0; i < 60; i++) begin
      issue(16'($urandom), 16'($urandom), 4'($urandom), 2'($urandom), 1'($urandom),
            int'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    end
    drain();

    // Reset one cycle after an issue: the op must vanish
    issue(16'h7FFF, 16'h7FFF, 4'b0000, 2'b10, 1'b1, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    mdl_mr[0] = '0;
    mdl_mr[1] = '0;
    repeat (5) @(posedge clk);
    #1;
    check("rstmid_mr0", dut.mr_q[0], 40'h0);
    check("rstmid_mr1", dut.mr_q[1], 40'h0);
    check("rstmid_mos", mos, 1'b0);

    // Overflow and mos_clr on the same edge: set wins
    issue(16'hFFFF, 16'hFFFF, 4'b0000, 2'b01, 1'b0, 0, 1'b0);
    @(posedge clk);
    #1;
    mos_clr = 1'b1;
    @(posedge clk);
    #1;
    mos_clr = 1'b0;
    check("mos_set_wins", mos, 1'b1);
    drain();
    mos_clr = 1'b1;
    @(posedge clk);
    #1;
    mos_clr = 1'b0;
    check("mos_cleared", mos, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
